cam_capture_window: RTL and testbench



---
 rtl/cam_capture_window.sv | 144 ++++++++++++++
 tb/tb_cam_capture_window.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_window.sv
// OV7670 capture front end: assembles RGB565 byte pairs, tracks x/y and issues
// frame-atomic buffer writes for a WIN_W x WIN_H window, plus per-frame statistics.
module cam_capture_window #(
  parameter int WIN_W          = 256,
  parameter int WIN_H          = 256,
  parameter bit VS_ACTIVE_HIGH = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        href,
  input  logic [7:0]  data,
  input  logic        capture_en,
  input  logic        err_clr,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic        frame_done,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [15:0] wr_data,
  output logic [8:0]  lines_last,
  output logic [9:0]  ppl_last,
  output logic        err_odd_byte
);

  localparam logic [9:0] X_MAX = 10'd1023;
  localparam logic [8:0] Y_MAX = 9'd511;

  typedef enum logic {PH_HI, PH_LO} phase_t;

  // Input stage: every camera-side input is registered together so that
  // capture_en and err_clr line up with the vsync/href they accompany.
  logic       r_vs_s1, r_href_s1, r_cap_s1, r_clr_s1;
  logic [7:0] r_data_s1;
  logic       r_vs_prev, r_href_prev;

  logic [9:0]  r_x;
  logic [8:0]  r_y;
  phase_t      r_phase;
  logic [7:0]  r_hi;
  logic        r_cap_latched;

  logic        r_pix_valid, r_frame_done, r_wr_en, r_err;
  logic [15:0] r_pix_data, r_wr_addr, r_wr_data;
  logic [8:0]  r_lines_last;
  logic [9:0]  r_ppl_last;

  logic w_vs_act, w_vs_act_prev, w_frame_start, w_byte, w_href_fall;
  logic w_in_win, w_err_set;

  assign w_vs_act      = VS_ACTIVE_HIGH ? r_vs_s1   : ~r_vs_s1;
  assign w_vs_act_prev = VS_ACTIVE_HIGH ? r_vs_prev : ~r_vs_prev;
  assign w_frame_start = w_vs_act & ~w_vs_act_prev;
  // href is only meaningful outside vertical blanking.
  assign w_byte        = ~w_vs_act & r_href_s1;
  assign w_href_fall   = ~w_vs_act & ~r_href_s1 & r_href_prev;
  assign w_in_win      = r_cap_latched & (r_x < 10'(WIN_W)) & (r_y < 9'(WIN_H));
  assign w_err_set     = w_href_fall & (r_phase == PH_LO);

  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs_s1       <= 1'b0;
      r_href_s1     <= 1'b0;
      r_cap_s1      <= 1'b0;
      r_clr_s1      <= 1'b0;
      r_data_s1     <= 8'd0;
      r_vs_prev     <= 1'b0;
      r_href_prev   <= 1'b0;
      r_x           <= 10'd0;
      r_y           <= 9'd0;
      r_phase       <= PH_HI;
      r_hi          <= 8'd0;
      r_cap_latched <= 1'b0;
      r_pix_valid   <= 1'b0;
      r_pix_data    <= 16'd0;
      r_frame_done  <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= 16'd0;
      r_wr_data     <= 16'd0;
      r_lines_last  <= 9'd0;
      r_ppl_last    <= 10'd0;
      r_err         <= 1'b0;
    end else begin
      r_vs_s1     <= vsync;
      r_href_s1   <= href;
      r_cap_s1    <= capture_en;
      r_clr_s1    <= err_clr;
      r_data_s1   <= data;
      r_vs_prev   <= r_vs_s1;
      r_href_prev <= r_href_s1;

      r_pix_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= 16'd0;
      r_wr_data    <= 16'd0;

      if (w_frame_start) begin
        r_frame_done  <= 1'b1;
        r_lines_last  <= r_y;
        r_x           <= 10'd0;
        r_y           <= 9'd0;
        r_phase       <= PH_HI;
        r_cap_latched <= r_cap_s1;
      end else if (w_byte) begin
        if (r_phase == PH_HI) begin
          r_hi    <= r_data_s1;
          r_phase <= PH_LO;
        end else begin
          r_pix_valid <= 1'b1;
          r_pix_data  <= {r_hi, r_data_s1};
          r_phase     <= PH_HI;
          r_x         <= (r_x == X_MAX) ? r_x : r_x + 10'd1;
          if (w_in_win) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= {r_y[7:0], r_x[7:0]};
            r_wr_data <= {r_hi, r_data_s1};
          end
        end
      end else if (w_href_fall) begin
        r_ppl_last <= r_x;
        r_x        <= 10'd0;
        r_phase    <= PH_HI;
        if (r_x != 10'd0 && r_y != Y_MAX) r_y <= r_y + 9'd1;
      end

      // A half pixel at end of line wins over a simultaneous clear.
      if (w_err_set)     r_err <= 1'b1;
      else if (r_clr_s1) r_err <= 1'b0;
    end
  end

  assign pix_valid    = r_pix_valid;
  assign pix_data     = r_pix_data;
  assign frame_done   = r_frame_done;
  assign wr_en        = r_wr_en;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign lines_last   = r_lines_last;
  assign ppl_last     = r_ppl_last;
  assign err_odd_byte = r_err;

endmodule

// File: tb/tb_cam_capture_window.sv
// Bench for cam_capture_window: a frame-level model predicts every output cycle
// for a full-size and a 128x64 instance; directed frames pin the model with literals.
module tb_cam_capture_window;

  localparam int W1 = 128;
  localparam int H1 = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vsync = 1'b0, href = 1'b0, capture_en = 1'b0, err_clr = 1'b0;
  logic [7:0] data = 8'd0;

  logic        o0_pix_valid, o0_frame_done, o0_wr_en, o0_err;
  logic [15:0] o0_pix_data, o0_wr_addr, o0_wr_data;
  logic [8:0]  o0_lines_last;
  logic [9:0]  o0_ppl_last;
  logic        o1_pix_valid, o1_frame_done, o1_wr_en, o1_err;
  logic [15:0] o1_pix_data, o1_wr_addr, o1_wr_data;
  logic [8:0]  o1_lines_last;
  logic [9:0]  o1_ppl_last;

  cam_capture_window u_dut0 (
    .clk(clk), .rst(rst), .vsync(vsync), .href(href), .data(data),
    .capture_en(capture_en), .err_clr(err_clr),
    .pix_valid(o0_pix_valid), .pix_data(o0_pix_data), .frame_done(o0_frame_done),
    .wr_en(o0_wr_en), .wr_addr(o0_wr_addr), .wr_data(o0_wr_data),
    .lines_last(o0_lines_last), .ppl_last(o0_ppl_last), .err_odd_byte(o0_err)
  );

  cam_capture_window #(.WIN_W(W1), .WIN_H(H1)) u_dut1 (
    .clk(clk), .rst(rst), .vsync(vsync), .href(href), .data(data),
    .capture_en(capture_en), .err_clr(err_clr),
    .pix_valid(o1_pix_valid), .pix_data(o1_pix_data), .frame_done(o1_frame_done),
    .wr_en(o1_wr_en), .wr_addr(o1_wr_addr), .wr_data(o1_wr_data),
    .lines_last(o1_lines_last), .ppl_last(o1_ppl_last), .err_odd_byte(o1_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 50) $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    bit          valid;
    bit          pv;
    logic [15:0] pd;
    bit          fd;
    bit          we0;
    logic [15:0] wa0, wd0;
    bit          we1;
    logic [15:0] wa1, wd1;
    logic [8:0]  ll;
    logic [9:0]  pl;
    bit          err;
  } exp_t;

  exp_t ring[8];

  // Frame-level model state (plain integers, updated per applied input cycle)
  int          m_x, m_y, m_lines, m_ppl;
  bit          m_ph, m_cap, m_err, m_pvs, m_phr;
  logic [7:0]  m_hi;
  logic [15:0] m_pd;

  function automatic exp_t zero_exp();
    exp_t e;
    e = '{default: 0};
    e.valid = 1'b1;
    return e;
  endfunction

  function automatic void model_reset();
    m_x = 0; m_y = 0; m_lines = 0; m_ppl = 0;
    m_ph = 0; m_cap = 0; m_err = 0; m_pvs = 0; m_phr = 0;
    m_hi = 8'd0; m_pd = 16'd0;
  endfunction

  // Apply one input cycle; the outputs it causes appear two clocks later.
  task automatic step(input bit vs, input bit hr, input logic [7:0] d);
    exp_t        e;
    bit          set_err;
    logic [15:0] pix;
    vsync = vs; href = hr; data = d;
    e = zero_exp();
    set_err = 0;
    if (vs && !m_pvs) begin
      e.fd = 1; m_lines = m_y; m_x = 0; m_y = 0; m_ph = 0; m_cap = capture_en;
    end else if (!vs) begin
      if (hr) begin
        if (!m_ph) begin
          m_hi = d; m_ph = 1;
        end else begin
          pix = {m_hi, d};
          m_pd = pix; e.pv = 1;
          if (m_cap && m_x < 256 && m_y < 256) begin
            e.we0 = 1; e.wa0 = {8'(m_y), 8'(m_x)}; e.wd0 = pix;
          end
          if (m_cap && m_x < W1 && m_y < H1) begin
            e.we1 = 1; e.wa1 = {8'(m_y), 8'(m_x)}; e.wd1 = pix;
          end
          if (m_x < 1023) m_x++;
          m_ph = 0;
        end
      end else if (m_phr) begin
        m_ppl = m_x;
        if (m_x != 0 && m_y < 511) m_y++;
        m_x = 0;
        if (m_ph) begin set_err = 1; m_ph = 0; end
      end
    end
    if (set_err) m_err = 1;
    else if (err_clr) m_err = 0;
    m_pvs = vs; m_phr = hr;
    e.pd = m_pd; e.ll = 9'(m_lines); e.pl = 10'(m_ppl); e.err = m_err;
    ring[(cyc + 2) % 8] = e;
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    ring[(cyc + 1) % 8] = zero_exp();
    ring[(cyc + 2) % 8] = zero_exp();
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  int          cnt_we0, cnt_we1, cnt_fd;
  logic [15:0] last_wa0, max_wa1;

  task automatic clear_counts();
    cnt_we0 = 0; cnt_we1 = 0; cnt_fd = 0; last_wa0 = 16'd0; max_wa1 = 16'd0;
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    int   k;
    exp_t e;
    k = cyc % 8;
    if (ring[k].valid) begin
      e = ring[k];
      ring[k].valid = 1'b0;
      check("pix_valid",  o0_pix_valid,  e.pv);
      check("pix_data",   o0_pix_data,   e.pd);
      check("frame_done", o0_frame_done, e.fd);
      check("wr_en0",     o0_wr_en,      e.we0);
      check("wr_addr0",   o0_wr_addr,    e.wa0);
      check("wr_data0",   o0_wr_data,    e.wd0);
      check("lines_last", o0_lines_last, e.ll);
      check("ppl_last",   o0_ppl_last,   e.pl);
      check("err",        o0_err,        e.err);
      check("pix_valid1", o1_pix_valid,  e.pv);
      check("pix_data1",  o1_pix_data,   e.pd);
      check("frame_done1", o1_frame_done, e.fd);
      check("wr_en1",     o1_wr_en,      e.we1);
      check("wr_addr1",   o1_wr_addr,    e.wa1);
      check("wr_data1",   o1_wr_data,    e.wd1);
      check("lines_last1", o1_lines_last, e.ll);
      check("ppl_last1",  o1_ppl_last,   e.pl);
      check("err1",       o1_err,        e.err);
    end
    if (o0_wr_en) begin cnt_we0++; last_wa0 = o0_wr_addr; end
    if (o1_wr_en) begin cnt_we1++; if (o1_wr_addr > max_wa1) max_wa1 = o1_wr_addr; end
    if (o0_frame_done) cnt_fd++;
  end

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 8'd0);
  endtask

  task automatic vs_pulse();
    repeat (3) step(1'b1, 1'b0, 8'd0);
    idle(3);
  endtask

  task automatic line(input int nbytes, input int seed);
    for (int i = 0; i < nbytes; i++) step(1'b0, 1'b1, 8'(i * 37 + seed));
    idle(2);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ring[i].valid = 1'b0;
    model_reset();
    clear_counts();
    @(negedge clk); #1;
    do_reset();
    idle(2);
    check("reset_lines_last", o0_lines_last, 0);
    check("reset_wr_addr", o0_wr_addr, 0);

    // Frame A: 136x66 frame, capture on
    capture_en = 1'b1;
    clear_counts();
    vs_pulse();
    check("A_frame_done_once", cnt_fd, 1);
    for (int l = 0; l < 66; l++) line(272, l);
    vs_pulse();
    check("A_writes0", cnt_we0, 8976);
    check("A_last_addr0", last_wa0, 16'h4187);
    check("A_writes1", cnt_we1, 8192);
    check("A_max_addr1", max_wa1, 16'h3F7F);
    check("A_lines_last", o0_lines_last, 66);
    check("A_ppl_last", o0_ppl_last, 136);

    // Frame B: x saturation at 1023, y saturation at 511
    clear_counts();
    line(2060, 1);
    check("B_ppl_sat", o0_ppl_last, 1023);
    for (int l = 0; l < 520; l++) line(2, l);
    vs_pulse();
    check("B_lines_sat", o0_lines_last, 511);
    check("B_writes0", cnt_we0, 511);
    check("B_writes1", cnt_we1, 191);

    // Frame C: directed pixel, odd-byte error, clear, set-vs-clear
    line(12, 0);
    line(12, 1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'(i));
    step(1'b0, 1'b1, 8'hA5);
    step(1'b0, 1'b1, 8'h3C);
    check("C_pv_not_yet", o0_pix_valid, 0);
    step(1'b0, 1'b0, 8'd0);
    check("C_pv", o0_pix_valid, 1);
    check("C_pix_data", o0_pix_data, 16'hA53C);
    check("C_wr_en", o0_wr_en, 1);
    check("C_wr_addr", o0_wr_addr, 16'h0205);
    idle(2);
    line(11, 3);
    check("C_err_set", o0_err, 1);
    check("C_ppl_odd", o0_ppl_last, 5);
    line(12, 4);
    err_clr = 1'b1;
    step(1'b0, 1'b0, 8'd0);
    err_clr = 1'b0;
    idle(2);
    check("C_err_clr", o0_err, 0);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 8'(i + 9));
    err_clr = 1'b1;
    step(1'b0, 1'b0, 8'd0);
    err_clr = 1'b0;
    idle(2);
    check("C_set_beats_clr", o0_err, 1);

    // Frame D/E: capture off at frame start, raised mid-frame
    capture_en = 1'b0;
    vs_pulse();
    clear_counts();
    for (int l = 0; l < 10; l++) begin
      if (l == 3) capture_en = 1'b1;
      line(16, l);
    end
    vs_pulse();
    check("D_no_writes0", cnt_we0, 0);
    check("D_no_writes1", cnt_we1, 0);
    clear_counts();
    for (int l = 0; l < 10; l++) line(16, l);
    vs_pulse();
    check("E_writes0", cnt_we0, 80);
    check("E_writes1", cnt_we1, 80);
    check("E_lines_last", o0_lines_last, 10);

    // Frame F: reset mid-line, then resume after a frame start with href high
    for (int l = 0; l < 50; l++) line(220, l);
    for (int i = 0; i < 200; i++) step(1'b0, 1'b1, 8'(i));
    do_reset();
    check("F_rst_wr_en", o0_wr_en, 0);
    check("F_rst_ppl", o0_ppl_last, 0);
    check("F_rst_lines", o0_lines_last, 0);
    check("F_rst_err", o0_err, 0);
    clear_counts();
    for (int i = 200; i < 220; i++) step(1'b0, 1'b1, 8'(i));
    idle(2);
    line(220, 1);
    line(220, 2);
    check("F_no_writes_after_rst", cnt_we0, 0);
    step(1'b1, 1'b1, 8'hEE);
    step(1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b0, 8'd0);
    idle(3);
    check("F_frame_done", cnt_fd, 1);
    clear_counts();
    for (int l = 0; l < 3; l++) line(8, l);
    vs_pulse();
    check("F_writes0", cnt_we0, 12);
    check("F_writes1", cnt_we1, 12);
    check("F_lines_last", o0_lines_last, 3);
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
